// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_unit
// Brief    : Handshaked operand/opcode issue and result capture for the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_unit #(
    parameter int WIDTH  = 16,
    parameter int OPW    = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OPW-1:0]   req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_cout,
    input  logic             alu_zero,
    input  logic             alu_error,
    input  logic [1:0]       alu_compareVal,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_error,
    output logic [1:0]       rsp_compare,
    output logic [7:0]       err_count,
    output logic             busy
);

    localparam int         c_CNT_W     = 4;
    localparam logic [3:0] c_SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_alu_a;
    logic [WIDTH-1:0]     r_alu_b;
    logic [OPW-1:0]       r_alu_op;
    logic [WIDTH-1:0]     r_rsp_r;
    logic                 r_rsp_cout;
    logic                 r_rsp_zero;
    logic                 r_rsp_error;
    logic [1:0]           r_rsp_cmp;
    logic [7:0]           r_err_count;
    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // HOLD forwards rsp_ready to req_ready so a retiring response can overlap
    // with acceptance of the next request in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_req_ready = rsp_ready;
                if (rsp_ready) begin
                    w_state_nxt = req_valid ? DRIVE : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept = req_valid & w_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_r     <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_cmp   <= '0;
            r_err_count <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= req_a;
                r_alu_b  <= req_b;
                r_alu_op <= req_op;
                r_cnt    <= c_SETTLE_M1;
            end else if (r_state == DRIVE && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_r     <= alu_r;
                r_rsp_cout  <= alu_cout;
                r_rsp_zero  <= alu_zero;
                r_rsp_error <= alu_error;
                r_rsp_cmp   <= alu_compareVal;
                if (alu_error && r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    // Gated by reset so every output reads 0 while reset is asserted.
    assign req_ready   = w_req_ready & ~reset;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_opcode  = r_alu_op;
    assign rsp_valid   = (r_state == HOLD);
    assign rsp_r       = r_rsp_r;
    assign rsp_cout    = r_rsp_cout;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_error   = r_rsp_error;
    assign rsp_compare = r_rsp_cmp;
    assign err_count   = r_err_count;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_unit
// Brief    : Directed bench for alu_issue_unit with a small behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Opcodes: 0 add, 1 sub (cout = borrow), 2 and, others raise error.
    // compareVal: 00 a==b, 01 a<b, 10 a>b.
    function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                               input logic [3:0] op);
        logic [16:0] s;
        logic [1:0]  cmp;
        logic        err;
        err = 1'b0;
        case (op)
            4'h0:    s = {1'b0, a} + {1'b0, b};
            4'h1:    s = {1'b0, a} - {1'b0, b};
            4'h2:    s = {1'b0, a & b};
            default: begin s = '0; err = 1'b1; end
        endcase
        cmp = (a == b) ? 2'b00 : ((a < b) ? 2'b01 : 2'b10);
        return {err, cmp, (s[15:0] == 16'h0), s[16], s[15:0]};
    endfunction

    // Instance with SETTLE=1
    logic        rv1 = 0, rr1, sv1, sr1 = 0;
    logic [15:0] ra1 = 0, rb1 = 0, aa1, ab1, ar1, sr_r1;
    logic [3:0]  ro1 = 0, ao1;
    logic        ac1, az1, ae1, s_c1, s_z1, s_e1, busy1;
    logic [1:0]  acmp1, s_cmp1;
    logic [7:0]  ec1;
    assign {ae1, acmp1, az1, ac1, ar1} = alu_model(aa1, ab1, ao1);

    alu_issue_unit #(.WIDTH(16), .OPW(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rr1),
        .req_a(ra1), .req_b(rb1), .req_op(ro1),
        .alu_a(aa1), .alu_b(ab1), .alu_opcode(ao1),
        .alu_r(ar1), .alu_cout(ac1), .alu_zero(az1), .alu_error(ae1),
        .alu_compareVal(acmp1), .rsp_valid(sv1), .rsp_ready(sr1),
        .rsp_r(sr_r1), .rsp_cout(s_c1), .rsp_zero(s_z1), .rsp_error(s_e1),
        .rsp_compare(s_cmp1), .err_count(ec1), .busy(busy1)
    );

    // Instance with SETTLE=3
    logic        rv3 = 0, rr3, sv3, sr3 = 0;
    logic [15:0] ra3 = 0, rb3 = 0, aa3, ab3, ar3, sr_r3;
    logic [3:0]  ro3 = 0, ao3;
    logic        ac3, az3, ae3, s_c3, s_z3, s_e3, busy3;
    logic [1:0]  acmp3, s_cmp3;
    logic [7:0]  ec3;
    assign {ae3, acmp3, az3, ac3, ar3} = alu_model(aa3, ab3, ao3);

    alu_issue_unit #(.WIDTH(16), .OPW(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rr3),
        .req_a(ra3), .req_b(rb3), .req_op(ro3),
        .alu_a(aa3), .alu_b(ab3), .alu_opcode(ao3),
        .alu_r(ar3), .alu_cout(ac3), .alu_zero(az3), .alu_error(ae3),
        .alu_compareVal(acmp3), .rsp_valid(sv3), .rsp_ready(sr3),
        .rsp_r(sr_r3), .rsp_cout(s_c3), .rsp_zero(s_z3), .rsp_error(s_e3),
        .rsp_compare(s_cmp3), .err_count(ec3), .busy(busy3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [15:0] r;
        logic        cout;
        logic        zero;
        logic        err;
        logic [1:0]  cmp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ec;
        vecs[0] = '{16'h0003, 16'h0004, 4'h0, 16'h0007, 1'b0, 1'b0, 1'b0, 2'b01};
        vecs[1] = '{16'hFFFF, 16'h0001, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b10};
        vecs[2] = '{16'h1234, 16'h1234, 4'h1, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00};
        vecs[3] = '{16'h0005, 16'h0007, 4'h1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 2'b01};
        vecs[4] = '{16'hF0F0, 16'h0FF0, 4'h2, 16'h00F0, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[5] = '{16'h0001, 16'h0002, 4'hF, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b01};
        exp_ec = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_a", aa1, 0);
        chk("rst_rsp_valid", sv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_err_count", ec1, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", rr1, 1);
        chk("post_rst_busy", busy1, 0);

        // Vector table, SETTLE=1, consumer always ready
        sr1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            rv1 = 1'b1; ra1 = vecs[i].a; rb1 = vecs[i].b; ro1 = vecs[i].op;
            @(negedge clk);
            chk("vec_req_ready", rr1, 1);
            @(posedge clk); #1;
            rv1 = 1'b0; ra1 = 16'hDEAD; rb1 = 16'hBEEF; ro1 = 4'h7;
            @(negedge clk);
            chk("vec_drive_busy", busy1, 1);
            chk("vec_drive_rsp_valid", sv1, 0);
            chk("vec_alu_a", aa1, vecs[i].a);
            chk("vec_alu_b", ab1, vecs[i].b);
            chk("vec_alu_op", ao1, vecs[i].op);
            @(posedge clk);
            @(negedge clk);
            exp_ec += int'(vecs[i].err);
            chk("vec_rsp_valid", sv1, 1);
            chk("vec_rsp_r", sr_r1, vecs[i].r);
            chk("vec_rsp_cout", s_c1, vecs[i].cout);
            chk("vec_rsp_zero", s_z1, vecs[i].zero);
            chk("vec_rsp_error", s_e1, vecs[i].err);
            chk("vec_rsp_compare", s_cmp1, vecs[i].cmp);
            chk("vec_err_count", ec1, exp_ec);
            @(posedge clk);
            @(negedge clk);
            chk("vec_back_idle", busy1, 0);
            chk("vec_rsp_valid_drop", sv1, 0);
            chk("vec_rsp_r_kept", sr_r1, vecs[i].r);
        end

        // Back-pressure with a second request pending
        sr1 = 1'b0;
        @(posedge clk); #1;
        rv1 = 1'b1; ra1 = 16'd10; rb1 = 16'd20; ro1 = 4'h0;
        @(posedge clk); #1;
        ra1 = 16'd100; rb1 = 16'd1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", sv1, 1);
            chk("bp_rsp_r", sr_r1, 16'd30);
            chk("bp_req_ready", rr1, 0);
            chk("bp_alu_a", aa1, 16'd10);
            @(posedge clk);
        end
        #1 sr1 = 1'b1;
        @(negedge clk);
        chk("bp_release_req_ready", rr1, 1);
        @(posedge clk); #1;
        rv1 = 1'b0;
        @(negedge clk);
        chk("bp_second_rsp_valid_drop", sv1, 0);
        chk("bp_second_alu_a", aa1, 16'd100);
        @(posedge clk);
        @(negedge clk);
        chk("bp_second_rsp_valid", sv1, 1);
        chk("bp_second_rsp_r", sr_r1, 16'd101);
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle", busy1, 0);

        // SETTLE=3: capture on the 3rd edge after accept
        sr3 = 1'b1;
        @(posedge clk); #1;
        rv3 = 1'b1; ra3 = 16'h0102; rb3 = 16'h0201; ro3 = 4'h0;
        @(posedge clk); #1;
        rv3 = 1'b0; ra3 = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3_rsp_valid_low", sv3, 0);
            chk("s3_busy", busy3, 1);
            chk("s3_alu_a_stable", aa3, 16'h0102);
            @(posedge clk);
        end
        @(negedge clk);
        chk("s3_rsp_valid", sv3, 1);
        chk("s3_rsp_r", sr_r3, 16'h0303);
        chk("s3_rsp_compare", s_cmp3, 2'b01);
        @(posedge clk);
        @(negedge clk);
        chk("s3_idle", busy3, 0);

        // Error saturation: back-to-back error ops, one capture per two edges
        @(posedge clk); #1;
        rv1 = 1'b1; ra1 = 16'h0001; rb1 = 16'h0001; ro1 = 4'hF;
        repeat (2 * 253) @(posedge clk);
        @(negedge clk);
        chk("sat_err_count_254", ec1, exp_ec + 253);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sat_err_count_255", ec1, 255);
        repeat (2 * 10) @(posedge clk);
        @(negedge clk);
        chk("sat_err_count_hold", ec1, 255);
        chk("sat_rsp_error", s_e1, 1);

        // Asynchronous reset while in DRIVE
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_err_count", ec1, 0);
        chk("mid_rst_rsp_valid", sv1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_alu_opcode", ao1, 0);
        chk("mid_rst_rsp_error", s_e1, 0);
        rv1 = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready", rr1, 1);
        chk("mid_rst_idle", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequential front end that owns the operand/opcode side of the 16-bit combinational ALU.
- Accepts operation requests over a valid/ready handshake and drives registered a/b/opcode into the ALU.
- Waits a programmable settle time, then captures r/cout/zero/error/compareVal into a result register and returns them over a second valid/ready handshake.
- Keeps a saturating count of operations whose ALU error flag was set.

Parameters:
- WIDTH, 16, operand and result width.
- OPW, 4, opcode width.
- SETTLE, 1, cycles the ALU inputs are held before capture. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts request this cycle.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_op  in  OPW  ALU opcode.
- alu_a  out  WIDTH  registered operand to ALU a.
- alu_b  out  WIDTH  registered operand to ALU b.
- alu_opcode  out  OPW  registered opcode to ALU.
- alu_r  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry out.
- alu_zero  in  1  ALU zero flag.
- alu_error  in  1  ALU error flag.
- alu_compareVal  in  2  ALU compare result.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes result this cycle.
- rsp_r  out  WIDTH  captured result.
- rsp_cout  out  1  captured carry.
- rsp_zero  out  1  captured zero.
- rsp_error  out  1  captured error.
- rsp_compare  out  2  captured compareVal.
- err_count  out  8  saturating count of captured error=1 results.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All outputs are 0: alu_a, alu_b, alu_opcode, rsp_*, rsp_valid, err_count, busy. The settle counter is 0.
- State IDLE:
  - req_ready=1.
  - When req_valid=1, register req_a/req_b/req_op onto alu_a/alu_b/alu_opcode, load cnt=SETTLE-1 and go to DRIVE.
- State DRIVE:
  - req_ready=0 and rsp_valid=0. ALU inputs are held stable.
  - If cnt==0, capture alu_r/cout/zero/error/compareVal into rsp_*, set rsp_valid=1 and go to HOLD. Otherwise decrement cnt.
  - On capture, if alu_error=1 and err_count!=255, increment err_count. At 255 it holds.
- State HOLD:
  - rsp_valid=1. rsp_* and alu_* are held stable.
  - req_ready = rsp_ready. This is a same-cycle back-to-back path.
  - rsp_ready=1 and req_valid=1: the response is retired, the new request is registered onto alu_*, cnt=SETTLE-1, next state is DRIVE, and rsp_valid drops next cycle.
  - rsp_ready=1 and req_valid=0: next state is IDLE and rsp_valid drops next cycle. rsp_* keep their last values.
  - rsp_ready=0: stay in HOLD indefinitely.
- Latency: with SETTLE=1, request accepted at edge N gives rsp_valid=1 after edge N+1.
  - Peak throughput is one op per SETTLE+1 cycles.
- req_* are sampled only on an accepting edge (req_valid & req_ready). Changes at other times are ignored.
- rsp_ready while rsp_valid=0 has no effect.
- Reset asserted mid-DRIVE or mid-HOLD:
  - Immediately returns to IDLE with all outputs 0.
  - The in-flight op is discarded and err_count clears.
- No arithmetic is performed in this block. The rsp_* fields are bit copies of the ALU outputs at the capture edge.
- busy = (state!=IDLE).

Test Plan:
Bench: connect the team ALU; opcode 4'h0 = add.
- Reset check: assert reset mid-cycle with no clock edge -> all outputs 0 at once; after release, req_ready=1 and busy=0.
- Single add, SETTLE=1: req a=16'h0003, b=16'h0004, op=0, rsp_ready=1 -> rsp_valid one cycle after the accept edge, rsp_r=16'h0007, cout=0, zero=0; then IDLE.
- Carry/zero: a=16'hFFFF, b=16'h0001, op=0 -> rsp_r=16'h0000, cout=1, zero=1.
- Back-pressure: hold rsp_ready=0 for 5 cycles with a second request pending.
  - During the stall: rsp_* stable, req_ready=0, alu_* unchanged.
  - When rsp_ready=1: the second request is accepted in that same cycle and its result follows one cycle later.
- SETTLE=3 parameter run: the capture edge is the 3rd edge after accept, and alu_* stay stable throughout DRIVE.
- Error saturation: 260 ops with alu_error=1 (error-producing opcode) -> err_count reaches 255 and holds. A reset mid-DRIVE -> err_count=0, rsp_valid=0, state IDLE.
